// File: rtl/pipeline_mem_arbiter.sv
// Shares one physical-memory port between the I-side and D-side stage caches.
// One transaction in flight at a time; simultaneous requests alternate grants and are counted.
module pipeline_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy,
    output logic [15:0]           conflict_count
);

    // state   | meaning
    // IDLE    | no transaction; arbitrate pending requests
    // SERVE_I | memory port owned by the instruction-fetch cache
    // SERVE_D | memory port owned by the memory-stage cache
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant_d;
    logic        last_grant_next;
    logic [15:0] conflict_q;
    logic        i_req;
    logic        d_req;
    logic        conflict;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            conflict_q   <= 16'h0000;
        end else begin
            state        <= state_next;
            last_grant_d <= last_grant_next;
            if (conflict && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end

    // Strobes decode from the registered state, so reset clears them without a clock.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant_d;
        conflict        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = i_address;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    conflict = 1'b1;
                    if (last_grant_d) begin
                        state_next      = SERVE_I;
                        last_grant_next = 1'b0;
                    end else begin
                        state_next      = SERVE_D;
                        last_grant_next = 1'b1;
                    end
                end else if (i_req) begin
                    state_next      = SERVE_I;
                    last_grant_next = 1'b0;
                end else if (d_req) begin
                    state_next      = SERVE_D;
                    last_grant_next = 1'b1;
                end
            end
            SERVE_I: begin
                pmem_read    = i_read;
                pmem_address = i_address;
                i_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                // An illegal read+write is resolved in favour of the write.
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                d_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pmem_wdata     = d_wdata;
    assign i_rdata        = pmem_rdata;
    assign d_rdata        = pmem_rdata;
    assign busy           = (state != IDLE);
    assign conflict_count = conflict_q;

endmodule

// File: doc/pipeline_mem_arbiter.md
# pipeline_mem_arbiter

Arbitrates the single physical-memory port between the instruction-fetch stage cache (I side, read-only) and the memory stage cache (D side, read/write) of the five-stage LC-3b pipeline. It holds one transaction at a time and routes the memory response to the granted requester only. It alternates grants on simultaneous requests and counts arbitration conflicts for performance analysis. It sits between the IF/MEM stage caches and the physical memory.

## Interface

Parameters:
- ADDR_WIDTH, 16, byte address width
- LINE_WIDTH, 128, cache line width in bits

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  I-side line read request
- i_address  in  ADDR_WIDTH  I-side line address
- i_resp  out  1  I-side transaction-complete pulse
- i_rdata  out  LINE_WIDTH  I-side read data
- d_read  in  1  D-side line read request
- d_write  in  1  D-side line write request
- d_address  in  ADDR_WIDTH  D-side line address
- d_wdata  in  LINE_WIDTH  D-side write data
- d_resp  out  1  D-side transaction-complete pulse
- d_rdata  out  LINE_WIDTH  D-side read data
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write data
- pmem_rdata  in  LINE_WIDTH  memory read data
- pmem_resp  in  1  memory transaction-complete pulse
- busy  out  1  a transaction is in flight (state is not IDLE)
- conflict_count  out  16  saturating count of cycles with I and D requesting simultaneously in IDLE

## Operation

- States: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- last_grant register: reset value is I. It is updated to the side granted on each IDLE-to-SERVE transition.
- IDLE behaviour:
  - i_req = i_read; d_req = d_read | d_write.
  - Only one side requesting: go to that side's SERVE state.
  - Both requesting: grant the side opposite last_grant, so the first conflict after reset goes to D. Increment conflict_count, saturating at 16'hFFFF.
  - Neither requesting: stay in IDLE.
- SERVE_I:
  - pmem_read = i_read; pmem_write = 0; pmem_address = i_address; pmem_wdata = d_wdata (don't-care).
- SERVE_D:
  - pmem_read = d_read & ~d_write; pmem_write = d_write; pmem_address = d_address; pmem_wdata = d_wdata.
  - Simultaneous d_read and d_write is illegal. If it occurs, the write is forwarded.
- Response routing:
  - i_resp = pmem_resp in SERVE_I; d_resp = pmem_resp in SERVE_D; otherwise both are 0.
  - i_rdata and d_rdata are driven directly from pmem_rdata in all states.
- Completion: pmem_resp in a SERVE state moves the arbiter to IDLE on the next edge.
- Request withdrawn before pmem_resp: this is a protocol violation. The arbiter stays in the SERVE state until pmem_resp.
- pmem_resp seen in IDLE is ignored.
- Requester contract: hold the request and its address/data stable until resp, then deassert in the cycle after resp.
- Reset mid-transaction:
  - State goes to IDLE, last_grant to I, conflict_count to 0.
  - All strobes and resps go to 0 immediately, without waiting for the clock.
  - The in-flight memory transaction is abandoned.

## Timing

- Reset values: pmem_read=0, pmem_write=0, i_resp=0, d_resp=0, busy=0, conflict_count=0. Address and data outputs are don't-care.
- Grant latency: a request first seen in IDLE in cycle N produces the memory strobe in cycle N+1. Strobes are decoded from the registered state and the held request.
- Response latency: pmem_resp in cycle M produces the requester resp in the same cycle M (combinational). busy drops in cycle M+1.
- Back-to-back: the minimum gap between two grants is one IDLE cycle. A request pending in cycle M+1 is granted in cycle M+2.
- Memory-side strobes never change while pmem_resp is low in a SERVE state, provided the requester obeys the contract.
- conflict_count updates on the same edge as the IDLE-to-SERVE transition.

## Test plan

- Lone I read at 16'h0040, memory responds after 3 cycles:
  - Required: pmem_read high from cycle 1 with pmem_address=16'h0040.
  - i_resp pulses together with pmem_resp, and i_rdata matches the memory data.
  - d_resp stays 0; busy returns to 0 one cycle after pmem_resp.
- Lone D write of 128'hDEAD…BEEF to 16'h1230:
  - Required: pmem_write=1, pmem_read=0, pmem_wdata and pmem_address forwarded.
  - d_resp pulses once.
- Simultaneous I and D requests straight after reset, both re-requesting immediately after each completion:
  - Required grant order: D, I, D, I.
  - conflict_count reaches 4 after four conflicting arbitrations.
- D granted; I asserts mid-transaction:
  - Required: I is not served until D's pmem_resp.
  - I's grant appears exactly 2 cycles after D's pmem_resp.
  - conflict_count does not increment for this case.
- Reset asserted during SERVE_D before pmem_resp:
  - Required: pmem_write, d_resp and busy go to 0 asynchronously.
  - After release, a lone I request is granted normally.
- Force 65536 conflicts:
  - Required: conflict_count saturates at 16'hFFFF and does not wrap.
